// File: rtl/data_memory_lsu_pkg.sv
// Shared constants, state encoding and byte-lane helper for the data memory LSU.
package data_memory_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} lsu_state_t;

  // Accepted-request attributes carried to the response cycle.
  typedef struct packed {
    logic       write;
    logic       err;
    logic [2:0] funct3;
    logic [1:0] lane;
  } lsu_req_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001;
      F3_H, F3_HU: m = 4'b0011;
      default:     m = 4'b1111;
    endcase
    return m << lane;
  endfunction

endpackage

// File: rtl/data_memory_lsu_align.sv
// Byte-lane steering: store data/mask placement and load lane extraction with extension.
module lsu_align
  import data_memory_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_lane,
  input  logic [XLEN-1:0] st_wdata,
  output logic [XLEN-1:0] st_data,
  output logic [3:0]      st_mask,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_lane,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    st_mask = byte_mask(st_funct3, st_lane);
    st_data = st_wdata << {st_lane, 3'b000};
    shifted = ld_word >> {ld_lane, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Word-organised data RAM with RV32 byte/half/word load-store front end,
// valid/ready request handshake and a zero-clear sweep after reset.
module data_memory_lsu
  import data_memory_lsu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  lsu_state_t      state, state_nx;
  logic [AW-1:0]   clear_idx;
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rd_word;
  lsu_req_t        cur, req;
  logic            accept, f3_legal, misaligned, out_of_range;
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] st_data, ld_data;
  logic [3:0]      st_mask;

  assign widx   = req_addr[AW+1:2];
  assign accept = req_valid & req_ready & ~reset;

  // Request decode and error classification.
  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~req_write;
      default:          f3_legal = 1'b0;
    endcase
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = (req_addr >> (AW + 2)) != '0;
    req = '{write:  req_write,
            err:    ~f3_legal | misaligned | out_of_range,
            funct3: req_funct3,
            lane:   req_addr[1:0]};
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_funct3 (req_funct3),
    .st_lane   (req_addr[1:0]),
    .st_wdata  (req_wdata),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .ld_funct3 (cur.funct3),
    .ld_lane   (cur.lane),
    .ld_word   (rd_word),
    .ld_data   (ld_data)
  );

  // RAM: sweep writes during CLEAR, masked byte writes for accepted clean stores.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clear_idx] <= '0;
    end else if (accept && req_write && !req.err) begin
      for (int b = 0; b < 4; b++)
        if (st_mask[b]) mem[widx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rd_word <= mem[widx];
  end

  always_ff @(posedge clk) begin
    if (reset)       cur <= '0;
    else if (accept) cur <= req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clear_idx <= clear_idx + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clear_idx == LAST_IDX) state_nx = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = (req_write || req.err || READ_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  // Stores and errors return zero data.
  always_comb begin
    rsp_valid = (state == RESP);
    rsp_error = rsp_valid & cur.err;
    rsp_rdata = (rsp_valid && !cur.err && !cur.write) ? ld_data : '0;
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench: two LSU configurations checked every cycle against a byte-array model.
module tb_data_memory_lsu;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, vld, wr;
  logic [1:0][2:0]  f3;
  logic [1:0][31:0] addr, wdata;
  wire  [1:0]       rdy, rv, rerr, bsy;
  wire  [1:0][31:0] rdata;

  data_memory_lsu #(.XLEN(32), .DEPTH_WORDS(256), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr[0]),
    .req_funct3(f3[0]), .req_addr(addr[0]), .req_wdata(wdata[0]), .rsp_valid(rv[0]),
    .rsp_rdata(rdata[0]), .rsp_error(rerr[0]), .busy(bsy[0]));

  data_memory_lsu #(.XLEN(32), .DEPTH_WORDS(16), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr[1]),
    .req_funct3(f3[1]), .req_addr(addr[1]), .req_wdata(wdata[1]), .rsp_valid(rv[1]),
    .rsp_rdata(rdata[1]), .rsp_error(rerr[1]), .busy(bsy[1]));

  function automatic int dep(input int d); return (d == 0) ? 256 : 16; endfunction
  function automatic int lat(input int d); return (d == 0) ? 1 : 2; endfunction

  // Model state: cycles of sweep left, cycles until the response is done, expected response.
  int          clr[2], ph[2], pulses[2];
  bit          inited[2];
  logic [31:0] er[2], last_rd[2];
  logic        ee[2], last_er[2];
  logic [7:0]  m[2][1024];
  int          vectors = 0, misses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int d);
    int n, a;
    logic [31:0] v;
    bit legal, err;
    if (rst[d]) begin
      clr[d] = dep(d); ph[d] = 0; inited[d] = 1;
      for (int i = 0; i < 1024; i++) m[d][i] = 8'h00;
    end else if (!inited[d]) begin
    end else if (clr[d] > 0) begin
      clr[d]--;
    end else if (ph[d] > 0) begin
      ph[d]--;
    end else if (vld[d]) begin
      n = 1 << f3[d][1:0];
      a = int'(addr[d][15:0]);
      legal = wr[d] ? (f3[d] <= 3'd2) : (f3[d] inside {LB, LH, LW, LBU, LHU});
      err = !legal || addr[d] >= 32'(4 * dep(d)) || (a % n) != 0;
      ee[d] = err; er[d] = '0;
      if (err) ph[d] = 1;
      else if (wr[d]) begin
        for (int i = 0; i < n; i++) m[d][a+i] = wdata[d][8*i +: 8];
        ph[d] = 1;
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v |= 32'(m[d][a+i]) << (8 * i);
        if (!f3[d][2] && n < 4 && v[8*n-1]) v |= 32'hFFFFFFFF << (8 * n);
        er[d] = v;
        ph[d] = lat(d);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) step(d);
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (inited[d]) begin
        chk($sformatf("req_ready[%0d]", d), 32'(rdy[d]), 32'(clr[d] == 0 && ph[d] == 0));
        chk($sformatf("busy[%0d]", d), 32'(bsy[d]), 32'(clr[d] > 0));
        chk($sformatf("rsp_valid[%0d]", d), 32'(rv[d]), 32'(ph[d] == 1));
        if (ph[d] == 1) begin
          chk($sformatf("rsp_rdata[%0d]", d), rdata[d], er[d]);
          chk($sformatf("rsp_error[%0d]", d), 32'(rerr[d]), 32'(ee[d]));
        end
      end
      if (rv[d] === 1'b1) begin
        pulses[d]++;
        last_rd[d] = rdata[d];
        last_er[d] = rerr[d];
      end
    end
  end

  // Returns at the negedge following the acceptance edge.
  task automatic issue(input int d, input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd);
    int k;
    k = 0;
    @(negedge clk);
    while (!(clr[d] == 0 && ph[d] == 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      vectors++; misses++;
      $display("FAIL issue_timeout[%0d]: ready never expected within 400 cycles", d);
    end
    wr[d] = w; f3[d] = f; addr[d] = a; wdata[d] = wd; vld[d] = 1'b1;
    @(negedge clk);
    vld[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int k;
    k = 0;
    while (ph[d] != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_rsp(input int d, input bit w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input string nm, input logic [31:0] exp_rd,
                        input bit exp_er);
    int p0;
    string t;
    p0 = pulses[d];
    t = $sformatf("%s.%s", (d == 0) ? "a" : "b", nm);
    issue(d, w, f, a, wd);
    wait_done(d);
    chk({t, "_pulses"}, 32'(pulses[d] - p0), 32'd1);
    chk({t, "_rdata"}, last_rd[d], exp_rd);
    chk({t, "_error"}, 32'(last_er[d]), 32'(exp_er));
  endtask

  task automatic suite(input int d, input logic [31:0] base, input logic [31:0] oor);
    do_rsp(d, 0, LW,  0,        0, "lw_clear_lo", 32'h0, 0);
    do_rsp(d, 0, LW,  oor - 4,  0, "lw_clear_hi", 32'h0, 0);
    do_rsp(d, 1, LW,  base,     32'hDEADBEEF, "sw", 32'h0, 0);
    do_rsp(d, 0, LW,  base,     0, "lw", 32'hDEADBEEF, 0);
    do_rsp(d, 0, LB,  base + 3, 0, "lb", 32'hFFFFFFDE, 0);
    do_rsp(d, 0, LBU, base + 3, 0, "lbu", 32'h000000DE, 0);
    do_rsp(d, 0, LH,  base + 2, 0, "lh", 32'hFFFFDEAD, 0);
    do_rsp(d, 0, LHU, base,     0, "lhu", 32'h0000BEEF, 0);
    do_rsp(d, 1, LB,  base + 1, 32'h12345655, "sb", 32'h0, 0);
    do_rsp(d, 0, LW,  base,     0, "lw_after_sb", 32'hDEAD55EF, 0);
    do_rsp(d, 1, LH,  base + 2, 32'h0000CAFE, "sh", 32'h0, 0);
    do_rsp(d, 0, LW,  base,     0, "lw_after_sh", 32'hCAFE55EF, 0);
    do_rsp(d, 1, LW,  base + 2, 32'h11111111, "sw_misaligned", 32'h0, 1);
    do_rsp(d, 0, LH,  base + 1, 0, "lh_misaligned", 32'h0, 1);
    do_rsp(d, 0, LW,  oor,      0, "lw_out_of_range", 32'h0, 1);
    do_rsp(d, 0, 3'b011, base,  0, "load_f3_011", 32'h0, 1);
    do_rsp(d, 1, LBU, base,     32'hFFFFFFFF, "store_f3_100", 32'h0, 1);
    do_rsp(d, 0, LW,  base,     0, "lw_after_errors", 32'hCAFE55EF, 0);
    do_rsp(d, 1, LW,  oor - 4,  32'hA5A50001, "sw_last_word", 32'h0, 0);
    do_rsp(d, 0, LW,  oor - 4,  0, "lw_last_word", 32'hA5A50001, 0);
    do_rsp(d, 0, LB,  oor - 1,  0, "lb_last_byte", 32'hFFFFFFA5, 0);
  endtask

  initial begin
    int p0;
    rst = '1; vld = '0; wr = '0; f3 = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = '0;
    suite(0, 32'h100, 32'h400);
    suite(1, 32'h20, 32'h40);
    // Reset during the WAIT cycle of a latency-2 load drops the response.
    p0 = pulses[1];
    issue(1, 0, LW, 32'h20, 0);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("b.no_rsp_after_reset", 32'(pulses[1] - p0), 32'd0);
    do_rsp(1, 0, LW, 32'h20, 0, "lw_after_reclear", 32'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
Parametrised successor to the single-cycle data memory: a word-organised data RAM with a load/store front end for RV32 byte, half and word accesses. It takes ALU-computed addresses plus funct3 from the datapath and answers each request with a single-cycle response pulse. It adds a valid/ready request handshake, configurable read latency, misalignment and range error reporting, and a hardware zero-clear sweep after reset.

Parameters:
XLEN, 32, data and address width
DEPTH_WORDS, 256, number of XLEN-bit words; power of two, at least 4
READ_LATENCY, 1, load response latency in cycles after acceptance; legal values 1 or 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3 access size and sign
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data; low bytes used for sb and sh
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  XLEN  load result; 0 for stores and errors
rsp_error  out  1  qualifies rsp_valid: misaligned, out-of-range or illegal funct3
busy  out  1  high in CLEAR state

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=1, state=CLEAR, clear_idx=0.
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR: writes zero to word clear_idx each cycle. Moves to IDLE after index DEPTH_WORDS-1, so the sweep lasts exactly DEPTH_WORDS cycles after reset deasserts. req_ready=0 throughout.
- IDLE: req_ready=1. A request is accepted on a rising edge where req_valid and req_ready are both 1.
  - Goes to RESP if the request is a store, an error, or READ_LATENCY=1.
  - Otherwise goes to WAIT.
- WAIT: lasts one cycle, then goes to RESP. req_ready=0.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0.
- Single outstanding request; back-to-back acceptances are at least 2 cycles apart (3 for latency-2 loads).
- Response timing after acceptance edge T:
  - Stores and errors: rsp_valid during cycle T+1.
  - Loads: rsp_valid during cycle T+READ_LATENCY.
- There is no response backpressure.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]; byte lane = req_addr[1:0]; storage is little-endian.
- Errors: any error suppresses the store write and sets rsp_error=1 with rsp_rdata=0. Error conditions:
  - Out of range: req_addr >= 4*DEPTH_WORDS.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3:
    - Loads: anything other than 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
    - Stores: anything other than 000 sb, 001 sh, 010 sw.
- Stores: the write happens at the acceptance edge with a byte-enable mask derived from lane and size. Unselected bytes are unchanged.
- Loads: the memory is read at the acceptance edge and the lane is selected and extended at the response.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - A load accepted after a store's RESP returns the stored data.
- Reset mid-operation (WAIT or RESP): the pending response is dropped and rsp_valid stays 0. A store already accepted remains written; the following CLEAR sweep then zeroes memory.
- Reset asserted during CLEAR restarts the sweep at index 0.

Decomposition:
- Package data_memory_lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {CLEAR, IDLE, WAIT, RESP}.
  - Function byte_mask(funct3, lane) returning 4 bits.
- Sub-module lsu_align: combinational.
  - Store path: shifts req_wdata into the lane and produces the byte mask.
  - Load path: selects the lane and sign- or zero-extends it.
- The FSM, clear counter and RAM array live in data_memory_lsu.

Test Plan:
- DEPTH_WORDS=16, reset held 3 cycles then released -> busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1. An lw of any address 0..0x3C returns 0x00000000.
- sw 0xDEADBEEF @0x100, then lw @0x100 -> rsp_rdata=0xDEADBEEF, rsp_error=0. rsp_valid is 1 cycle after acceptance for READ_LATENCY=1 and 2 cycles after for READ_LATENCY=2.
- With 0xDEADBEEF @0x100:
  - lb @0x103 -> 0xFFFFFFDE
  - lbu @0x103 -> 0x000000DE
  - lh @0x102 -> 0xFFFFDEAD
  - lhu @0x100 -> 0x0000BEEF
- sb wdata 0x12345655 @0x101, then lw @0x100 -> 0xDEAD55EF. sh wdata 0x0000CAFE @0x102, then lw @0x100 -> 0xCAFE55EF.
- Error cases, each giving rsp_error=1 and rsp_rdata=0 one cycle after acceptance, with memory unchanged on a re-read:
  - sw @0x102
  - lh @0x101
  - lw @0x400 with DEPTH_WORDS=256
  - load with funct3=011
- READ_LATENCY=2: accept lw, then assert reset in the WAIT cycle -> no rsp_valid pulse; CLEAR restarts and req_ready stays 0 for DEPTH_WORDS cycles.
